// File: rtl/mult_pkg.sv
// Shared widths, stage-A record and carry-save half adder for the X2 multiplier stage.
package mult_pkg;

    localparam int MULT_CSA_W = 64;
    localparam int MULT_RES_W = 32;
    localparam int X1X2_W     = 130;
    localparam int X2WB_DEPTH = 2;
    localparam int X2WB_W     = MULT_RES_W + 1;

    typedef struct packed {
        logic                  valid;
        logic [MULT_RES_W-1:0] lo;
        logic                  carry;
        logic [MULT_RES_W-1:0] s0_hi;
        logic [MULT_RES_W-1:0] s1_hi;
        logic                  sel;
        logic                  sgn;
    } stage_a_t;

    function automatic logic [MULT_RES_W:0] add_half(input logic [MULT_RES_W-1:0] a,
                                                     input logic [MULT_RES_W-1:0] b,
                                                     input logic              cin);
        add_half = {1'b0, a} + {1'b0, b} + {{MULT_RES_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/x2_multiplier_if.sv
// Handshake/data bundle between the X1X2 FIFO, the X2 stage and the writeback consumer.
interface x2_multiplier_if;
    import mult_pkg::*;

    logic [2*MULT_CSA_W-1:0] RES_RX1;
    logic                    SELECT_MSB_RX1;
    logic                    SIGNED_RES_RX1;
    logic                    X1X2_EMPTY_SX1;
    logic                    X1X2_POP_SX2;
    logic                    FLUSH_SX2;
    logic                    X2WB_POP_SWB;
    logic [MULT_RES_W-1:0]   RES_RX2;
    logic                    SIGNED_RES_RX2;
    logic                    X2WB_EMPTY_SX2;

    modport slave (
        input  RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1, FLUSH_SX2, X2WB_POP_SWB,
        output X1X2_POP_SX2, RES_RX2, SIGNED_RES_RX2, X2WB_EMPTY_SX2
    );

    modport master (
        output RES_RX1, SELECT_MSB_RX1, SIGNED_RES_RX1, X1X2_EMPTY_SX1, FLUSH_SX2, X2WB_POP_SWB,
        input  X1X2_POP_SX2, RES_RX2, SIGNED_RES_RX2, X2WB_EMPTY_SX2
    );

endinterface

// File: rtl/x2_out_buffer.sv
// Two-entry FIFO holding {signed, result word}; head reads as zero while empty.
module x2_out_buffer
    import mult_pkg::*;
#(
    parameter int W = X2WB_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem_r [0:X2WB_DEPTH-1];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         pop_eff_s;
    logic         push_eff_s;

    // Qualify requests: pops on empty are dropped, a full buffer takes a push only alongside a pop.
    always_comb begin
        empty      = (count_r == 2'd0);
        full       = (count_r == 2'd2);
        pop_eff_s  = pop & ~empty & ~flush;
        push_eff_s = push & ~flush & (~full | pop_eff_s);
        if (empty) begin
            head_data = {W{1'b0}};
        end else begin
            head_data = mem_r[rd_ptr_r];
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            for (int i = 0; i < X2WB_DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_eff_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_eff_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/x2_multiplier.sv
// Second multiply stage: resolves the 64-bit carry-save pair in two 32-bit halves and
// queues the selected word for writeback.
module x2_multiplier
    import mult_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    x2_multiplier_if.slave  bus
);

    stage_a_t              stage_a_r;
    logic                  reset_q_r;
    logic [MULT_RES_W:0]   lo_sum_s;
    logic [MULT_RES_W-1:0] hi_word_s;
    logic                  advance_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  buf_full_s;
    logic                  buf_empty_s;
    logic [X2WB_W-1:0]     push_data_s;
    logic [X2WB_W-1:0]     head_s;

    // Stage-B adder, handshake and output gating; nothing moves while reset or flush is active.
    always_comb begin
        lo_sum_s  = add_half(bus.RES_RX1[MULT_RES_W-1:0],
                             bus.RES_RX1[MULT_CSA_W +: MULT_RES_W], 1'b0);
        hi_word_s = stage_a_r.s0_hi + stage_a_r.s1_hi + {{(MULT_RES_W-1){1'b0}}, stage_a_r.carry};
        advance_s = stage_a_r.valid & (~buf_full_s | bus.X2WB_POP_SWB);
        push_s    = advance_s & ~bus.FLUSH_SX2 & ~reset;
        pop_s     = ~bus.X1X2_EMPTY_SX1 & ~bus.FLUSH_SX2 & ~reset & ~reset_q_r
                  & (~stage_a_r.valid | advance_s);
        if (stage_a_r.sel) begin
            push_data_s = {stage_a_r.sgn, hi_word_s};
        end else begin
            push_data_s = {stage_a_r.sgn, stage_a_r.lo};
        end
        bus.X1X2_POP_SX2 = pop_s;
        if (reset) begin
            bus.X2WB_EMPTY_SX2 = 1'b1;
            bus.RES_RX2        = {MULT_RES_W{1'b0}};
            bus.SIGNED_RES_RX2 = 1'b0;
        end else begin
            bus.X2WB_EMPTY_SX2 = buf_empty_s;
            bus.RES_RX2        = head_s[MULT_RES_W-1:0];
            bus.SIGNED_RES_RX2 = head_s[MULT_RES_W];
        end
    end

    // Holds off the X1X2 pop for one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            reset_q_r <= 1'b1;
        end else begin
            reset_q_r <= 1'b0;
        end
    end

    // Stage-A register: low-half sum and carry plus the high halves for stage B.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_a_r <= {$bits(stage_a_t){1'b0}};
        end else if (bus.FLUSH_SX2) begin
            stage_a_r.valid <= 1'b0;
        end else if (pop_s) begin
            stage_a_r.valid <= 1'b1;
            stage_a_r.lo    <= lo_sum_s[MULT_RES_W-1:0];
            stage_a_r.carry <= lo_sum_s[MULT_RES_W];
            stage_a_r.s0_hi <= bus.RES_RX1[MULT_RES_W +: MULT_RES_W];
            stage_a_r.s1_hi <= bus.RES_RX1[MULT_CSA_W + MULT_RES_W +: MULT_RES_W];
            stage_a_r.sel   <= bus.SELECT_MSB_RX1;
            stage_a_r.sgn   <= bus.SIGNED_RES_RX1;
        end else if (advance_s) begin
            stage_a_r.valid <= 1'b0;
        end else begin
            stage_a_r <= stage_a_r;
        end
    end

    x2_out_buffer #(.W(X2WB_W)) u_out_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.FLUSH_SX2),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (bus.X2WB_POP_SWB),
        .head_data (head_s),
        .empty     (buf_empty_s),
        .full      (buf_full_s)
    );

endmodule

// File: tb/tb_x2_multiplier.sv
// Scoreboard bench for x2_multiplier: directed corner cases followed by random traffic with flushes.
module tb_x2_multiplier;
    import mult_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   pop_cnt = 0;
    logic pop_seen_r = 1'b0;
    logic [32:0] exp_q [$];
    logic [127:0] csa;
    logic [32:0]  e;

    x2_multiplier_if bus ();

    x2_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full 64-bit wrapped sum of the pair, then pick the requested half.
    function automatic logic [32:0] model(input logic [127:0] pair, input logic sel, input logic sg);
        logic [63:0] p;
        p = pair[63:0] + pair[127:64];
        return {sg, sel ? p[63:32] : p[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_head();
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) begin
            w[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        bus.RES_RX1        = {w[3], w[2], w[1], w[0]};
        bus.SELECT_MSB_RX1 = 1'($urandom_range(0, 1));
        bus.SIGNED_RES_RX1 = 1'($urandom_range(0, 1));
    endtask

    // Monitor: record every X1X2 pop as an expected result, compare on every consumer pop.
    always @(negedge clk) begin
        pop_seen_r = bus.X1X2_POP_SX2;
        if (bus.X1X2_POP_SX2 === 1'b1) begin
            pop_cnt++;
            exp_q.push_back(model(bus.RES_RX1, bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1));
        end
        if (bus.X2WB_EMPTY_SX2 === 1'b1) begin
            check("idle_zero", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, 64'd0);
        end else if (!reset && !bus.FLUSH_SX2 && bus.X2WB_POP_SWB) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, 64'hDEAD);
            end else begin
                check("result", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, {31'd0, exp_q.pop_front()});
            end
        end
        if (reset || bus.FLUSH_SX2) begin
            exp_q.delete();
        end
    end

    initial begin
        reset = 1'b1;
        bus.RES_RX1 = 128'd0;
        bus.SELECT_MSB_RX1 = 1'b0;
        bus.SIGNED_RES_RX1 = 1'b0;
        bus.X1X2_EMPTY_SX1 = 1'b0;
        bus.FLUSH_SX2 = 1'b0;
        bus.X2WB_POP_SWB = 1'b0;
        tick();
        #1;
        check("rst_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd0);
        check("rst_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd0);
        check("post_rst_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);
        bus.X1X2_EMPTY_SX1 = 1'b1;
        tick();

        // Carry from the low half into the high half.
        bus.RES_RX1 = {64'h1, 64'h0000_0000_FFFF_FFFF};
        bus.SELECT_MSB_RX1 = 1'b1;
        bus.X1X2_EMPTY_SX1 = 1'b0;
        #1;
        check("carry_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd1);
        tick();
        bus.X1X2_EMPTY_SX1 = 1'b1;
        #1;
        check("carry_n1_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);
        tick();
        check("carry_n2_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd0);
        check("carry_n2_res", {32'd0, bus.RES_RX2}, 64'd1);
        bus.X2WB_POP_SWB = 1'b1;
        tick();

        // 64-bit wrap, both halves, signed tag.
        bus.RES_RX1 = {64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
        bus.SELECT_MSB_RX1 = 1'b0;
        bus.SIGNED_RES_RX1 = 1'b1;
        bus.X1X2_EMPTY_SX1 = 1'b0;
        tick();
        bus.SELECT_MSB_RX1 = 1'b1;
        tick();
        bus.X1X2_EMPTY_SX1 = 1'b1;
        #1;
        check("wrap_lo", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, {31'd0, 1'b1, 32'd0});
        tick();
        check("wrap_hi", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, {31'd0, 1'b1, 32'd0});
        check("wrap_hi_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd0);
        tick();

        // Backpressure: exactly three pops fill buffer plus stage A.
        bus.X2WB_POP_SWB = 1'b0;
        bus.X1X2_EMPTY_SX1 = 1'b0;
        new_head();
        pop_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pop_seen_r) new_head();
        end
        check("stall_pops", pop_cnt, 64'd3);
        #1;
        check("stall_pop_low", {63'd0, bus.X1X2_POP_SX2}, 64'd0);

        // Full buffer popped while stage A advances: count stays at two.
        bus.X2WB_POP_SWB = 1'b1;
        #1;
        check("full_pop_adv", {63'd0, bus.X1X2_POP_SX2}, 64'd1);
        tick();
        if (pop_seen_r) new_head();
        bus.X2WB_POP_SWB = 1'b0;
        #1;
        check("full_again_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd0);
        check("full_again_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd0);

        // Release: one pop per cycle.
        bus.X2WB_POP_SWB = 1'b1;
        pop_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pop_seen_r) new_head();
        end
        check("stream_pops", pop_cnt, 64'd6);

        // Flush with three entries in flight.
        bus.X2WB_POP_SWB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pop_seen_r) new_head();
        end
        bus.FLUSH_SX2 = 1'b1;
        bus.X2WB_POP_SWB = 1'b1;
        #1;
        check("flush_no_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd0);
        tick();
        bus.FLUSH_SX2 = 1'b0;
        bus.X2WB_POP_SWB = 1'b0;
        bus.X1X2_EMPTY_SX1 = 1'b1;
        #1;
        check("flush_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);

        // Reset with buffer full and stage A valid.
        bus.X1X2_EMPTY_SX1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pop_seen_r) new_head();
        end
        reset = 1'b1;
        #1;
        check("midrst_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd0);
        check("midrst_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);
        check("midrst_res", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_after_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd0);
        check("midrst_after_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);
        bus.X1X2_EMPTY_SX1 = 1'b1;
        tick();
        tick();
        new_head();
        csa = bus.RES_RX1;
        e = model(csa, bus.SELECT_MSB_RX1, bus.SIGNED_RES_RX1);
        bus.X1X2_EMPTY_SX1 = 1'b0;
        #1;
        check("rel_pop", {63'd0, bus.X1X2_POP_SX2}, 64'd1);
        tick();
        bus.X1X2_EMPTY_SX1 = 1'b1;
        tick();
        check("rel_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd0);
        check("rel_res", {31'd0, bus.SIGNED_RES_RX2, bus.RES_RX2}, {31'd0, e});
        bus.X2WB_POP_SWB = 1'b1;
        tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            if (pop_seen_r || bus.X1X2_EMPTY_SX1) new_head();
            bus.X1X2_EMPTY_SX1 = ($urandom_range(0, 99) >= 70);
            bus.X2WB_POP_SWB   = ($urandom_range(0, 99) < 70);
            bus.FLUSH_SX2      = ($urandom_range(0, 99) < 2);
            tick();
        end

        // Drain and confirm nothing is left outstanding.
        bus.FLUSH_SX2 = 1'b0;
        bus.X1X2_EMPTY_SX1 = 1'b1;
        bus.X2WB_POP_SWB = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("drain_left", exp_q.size(), 64'd0);
        check("drain_empty", {63'd0, bus.X2WB_EMPTY_SX2}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
